// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through a round-robin arbiter.
// Single-cycle ops respond two cycles after accept. MUL runs 32 shift-add
// iterations on the shared adder, so it responds 33 cycles after accept.
// The response is held until the consumer takes it.
module alu_arbiter #(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [3:0]           req0_op,
  input  logic [WORD_SIZE-1:0] req0_a,
  input  logic [WORD_SIZE-1:0] req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [3:0]           req1_op,
  input  logic [WORD_SIZE-1:0] req1_a,
  input  logic [WORD_SIZE-1:0] req1_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_id,
  output logic [WORD_SIZE-1:0] resp_result,
  output logic                 resp_zero,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(WORD_SIZE);

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;
  localparam logic [3:0] OpMul = 4'b1000;
  localparam logic [3:0] OpNor = 4'b1100;

  typedef enum logic [1:0] {StIdle, StExec, StMul, StResp} state_e;

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [3:0]           op_q, op_d;
  logic [WORD_SIZE-1:0] a_q, a_d;     // operand A; multiplicand during MUL
  logic [WORD_SIZE-1:0] b_q, b_d;     // operand B; multiplier during MUL
  logic [WORD_SIZE-1:0] acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 id_q, id_d;
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic                 zero_q, zero_d;

  logic                 grant;
  logic                 any_valid;
  logic                 accept;
  logic [WORD_SIZE-1:0] add_a, add_b, add_sum;
  logic                 add_sub;
  logic                 slt;
  logic [WORD_SIZE-1:0] alu_result;
  logic [WORD_SIZE-1:0] mul_acc;

  // Round-robin pick: a lone valid wins, a tie goes to the one not granted last.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = req1_valid;
    end
  end

  assign accept     = (state_q == StIdle) && rst_n && any_valid;
  assign req0_ready = accept && req0_valid && !grant;
  assign req1_ready = accept && req1_valid && grant;

  // Shared adder: ALU add/sub/compare in EXEC, accumulate step in MUL.
  always_comb begin
    if (state_q == StMul) begin
      add_a   = acc_q;
      add_b   = a_q;
      add_sub = 1'b0;
    end else begin
      add_a   = a_q;
      add_b   = b_q;
      add_sub = (op_q == OpSub) || (op_q == OpSlt);
    end
  end

  assign add_sum = add_a + (add_b ^ {WORD_SIZE{add_sub}}) + WORD_SIZE'(add_sub);
  // Signed less-than: differing signs decide directly, else the difference sign.
  assign slt     = (a_q[WORD_SIZE-1] ^ b_q[WORD_SIZE-1]) ? a_q[WORD_SIZE-1]
                                                         : add_sum[WORD_SIZE-1];
  assign mul_acc = b_q[0] ? add_sum : acc_q;

  // Single-cycle ALU result decode on the latched op.
  always_comb begin
    alu_result = '0;
    case (op_q)
      OpAnd:   alu_result = a_q & b_q;
      OpOr:    alu_result = a_q | b_q;
      OpNor:   alu_result = ~(a_q | b_q);
      OpAdd:   alu_result = add_sum;
      OpSub:   alu_result = add_sum;
      OpSlt:   alu_result = {{(WORD_SIZE-1){1'b0}}, slt};
      default: alu_result = '0;
    endcase
  end

  // Next-state: accept, execute, iterate MUL, hold the response.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    result_d     = result_q;
    zero_d       = zero_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          last_grant_d = grant;
          id_d         = grant;
          op_d         = grant ? req1_op : req0_op;
          a_d          = grant ? req1_a : req0_a;
          b_d          = grant ? req1_b : req0_b;
          acc_d        = '0;
          cnt_d        = '0;
          state_d      = (op_d == OpMul) ? StMul : StExec;
        end
      end
      StExec: begin
        result_d = alu_result;
        zero_d   = (alu_result == '0);
        state_d  = StResp;
      end
      StMul: begin
        acc_d = mul_acc;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WORD_SIZE - 1)) begin
          result_d = mul_acc;
          zero_d   = (mul_acc == '0);
          state_d  = StResp;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
    end
  end

  assign resp_valid  = (state_q == StResp);
  assign resp_id     = id_q;
  assign resp_result = result_q;
  assign resp_zero   = zero_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: accepted requests push an expected response into a
// scoreboard queue; each response handshake pops and compares.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         resp_valid, resp_id, resp_zero, busy;
  logic         resp_ready = 1'b0;
  logic [W-1:0] resp_result;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic tb_last = 1'b1;
  logic [W+1:0] sb_q[$];

  alu_arbiter #(.WORD_SIZE(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_result(resp_result),
    .resp_zero  (resp_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference behaviour of one operation: {id, result, zero}.
  function automatic logic [W+1:0] model(input logic id, input logic [3:0] op,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: r = a * b;
      default: r = '0;
    endcase
    return {id, r, (r == '0)};
  endfunction

  // Scoreboard: push on accept, pop on response handshake, watch ready exclusivity.
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (rst_n) begin
      total++;
      if (req0_ready && req1_ready) begin
        bad++;
        $display("FAIL both_ready: req0_ready=%b req1_ready=%b, required not both high",
                 req0_ready, req1_ready);
      end
      if (req0_valid && req0_ready) begin
        sb_q.push_back(model(1'b0, req0_op, req0_a, req0_b));
        acc_cyc = cyc + 1;
        tb_last = 1'b0;
      end else if (req1_valid && req1_ready) begin
        sb_q.push_back(model(1'b1, req1_op, req1_a, req1_b));
        acc_cyc = cyc + 1;
        tb_last = 1'b1;
      end
      if (resp_valid && resp_ready) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL resp_unexpected: id=%0d result=%h, required no response",
                   resp_id, resp_result);
        end else begin
          e = sb_q.pop_front();
          if ({resp_id, resp_result, resp_zero} !== e) begin
            bad++;
            $display("FAIL resp_data: id=%0d result=%h zero=%b, required id=%0d result=%h zero=%b",
                     resp_id, resp_result, resp_zero, e[W+1], e[W:1], e[0]);
          end
        end
      end
    end
  end

  // Drive a request and hold it until accepted (bounded).
  task automatic send(input logic id, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    logic got;
    got = 1'b0;
    if (!id) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((!id && req0_ready) || (id && req1_ready)) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    if (!id) req0_valid = 1'b0; else req1_valid = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL send_timeout: id=%0d accepted=0, required accepted=1", id);
    end
  endtask

  // Wait for resp_valid (bounded); lat is cycles from accept edge, -1 on timeout.
  task automatic wait_resp(output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = cyc - acc_cyc + 1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({resp_valid, resp_id, resp_zero, busy, req0_ready, req1_ready} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: v=%b id=%b z=%b busy=%b r0=%b r1=%b, required all 0",
               resp_valid, resp_id, resp_zero, busy, req0_ready, req1_ready);
    end
    total++;
    if (resp_result !== '0) begin
      bad++;
      $display("FAIL reset_result: result=%h, required 0", resp_result);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_add_basic();
    int lat;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd5; req0_b = 32'd7;
    @(negedge clk);
    total++;
    if (req0_ready !== 1'b1) begin
      bad++;
      $display("FAIL add_ready: req0_ready=%b, required 1", req0_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_resp(lat);
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL add_latency: latency=%0d, required 2", lat);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL add_busy_after: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_ops();
    logic [3:0]   ops[8] = '{4'b0110, 4'b0111, 4'b1100, 4'b0101, 4'b0000, 4'b0001, 4'b0010,
                             4'b0111};
    logic [W-1:0] as[8]  = '{32'd9, 32'hFFFF_FFFF, 32'd0, 32'd77, 32'hF0F0_1234,
                             32'h0000_00F0, 32'hFFFF_FFFF, 32'd1};
    logic [W-1:0] bs[8]  = '{32'd9, 32'd1, 32'd0, 32'd33, 32'h0FF0_FF00, 32'h1200_000F,
                             32'd1, 32'hFFFF_FFFF};
    int lat;
    for (int i = 0; i < 8; i++) begin
      send(i[0], ops[i], as[i], bs[i]);
      wait_resp(lat);
      total++;
      if (lat !== 2) begin
        bad++;
        $display("FAIL op_latency[%0d]: latency=%0d, required 2", i, lat);
      end
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] as[4] = '{32'd7, 32'hFFFF_FFFF, 32'd0, 32'h0};
    logic [W-1:0] bs[4] = '{32'd6, 32'd2, 32'h1234_5678, 32'h0};
    int lat;
    as[3] = $urandom;
    bs[3] = $urandom;
    for (int i = 0; i < 4; i++) begin
      send(i[0], 4'b1000, as[i], bs[i]);
      wait_resp(lat);
      total++;
      if (lat !== 33) begin
        bad++;
        $display("FAIL mul_latency[%0d]: latency=%0d, required 33", i, lat);
      end
    end
  endtask

  task automatic test_round_robin();
    logic start;
    logic exp_g;
    logic got;
    logic g;
    resp_ready = 1'b1;
    start = ~tb_last;
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd100; req0_b = 32'd1;
    req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'd200; req1_b = 32'd2;
    for (int i = 0; i < 6; i++) begin
      exp_g = start ^ i[0];
      got = 1'b0;
      g = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin
          got = 1'b1;
          g = req1_ready;
          break;
        end
      end
      total++;
      if (!got || g !== exp_g) begin
        bad++;
        $display("FAIL rr_grant[%0d]: granted=%0d seen=%b, required granted=%0d",
                 i, g, got, exp_g);
      end
      @(posedge clk); #1;
      if (!g) req0_a = 32'd1000 + 32'(i * 3); else req1_a = 32'd2000 + 32'(i * 5);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    logic held;
    resp_ready = 1'b0;
    send(1'b0, 4'b0010, 32'd3, 32'd4);
    wait_resp(lat);
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL bp_latency: latency=%0d, required 2", lat);
    end
    req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'd10; req1_b = 32'd20;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      held = (resp_valid === 1'b1) && (resp_id === 1'b0) && (resp_result === 32'd7) &&
             (resp_zero === 1'b0) && (req1_ready === 1'b0) && (busy === 1'b1);
      total++;
      if (!held) begin
        bad++;
        $display("FAIL bp_hold[%0d]: v=%b id=%b res=%h z=%b r1=%b busy=%b, required 1 0 7 0 0 1",
                 i, resp_valid, resp_id, resp_result, resp_zero, req1_ready, busy);
      end
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (req1_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_next_accept: req1_ready=%b busy=%b, required 1 0", req1_ready, busy);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_resp(lat);
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL bp_next_latency: latency=%0d, required 2", lat);
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    logic quiet;
    resp_ready = 1'b1;
    send(1'b0, 4'b1000, 32'h1234, 32'h5678);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    tb_last = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({resp_valid, resp_id, resp_zero, busy, req0_ready, req1_ready} !== 6'b0 ||
        resp_result !== '0) begin
      bad++;
      $display("FAIL midreset_outputs: v=%b id=%b z=%b busy=%b r0=%b r1=%b res=%h, required 0",
               resp_valid, resp_id, resp_zero, busy, req0_ready, req1_ready, resp_result);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin
      bad++;
      $display("FAIL midreset_no_resp: quiet=%b, required 1", quiet);
    end
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd11; req0_b = 32'd22;
    req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'd33; req1_b = 32'd44;
    @(negedge clk);
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      bad++;
      $display("FAIL midreset_tie: r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_resp(lat);
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL midreset_add_latency: latency=%0d, required 2", lat);
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_ops();
    test_mul();
    test_round_robin();
    test_backpressure();
    test_reset_mid_mul();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drained: pending=%0d, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
